zapper_flash_ctrl: RTL and testbench



---
 rtl/zapper_flash_ctrl.sv | 164 ++++++++++++++++
 tb/tb_zapper_flash_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/zapper_flash_ctrl.sv
// Light-gun shot sequencer: frame-aligned black/white flash, hit judgement, ammo and cooldown.
// Define ZAPPER_STATS_EN to add saturating shots_total / hits_total counters.
module zapper_flash_ctrl #(
  parameter int SHOTS_PER_ROUND = 3,
  parameter int DETECT_MIN      = 16,
  parameter int LEAK_MAX        = 8,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       valid,
  input  logic       trigger,
  input  logic       detect,
  input  logic       duck_active,
  input  logic       round_start,
  output logic [1:0] flash_mode,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [2:0] shots_left,
`ifdef ZAPPER_STATS_EN
  output logic [7:0] shots_total,
  output logic [7:0] hits_total,
`endif
  output logic       busy
);

  localparam int WW = $clog2(DETECT_MIN + 2);
  localparam int LW = $clog2(LEAK_MAX + 2);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 2);
  localparam logic [WW-1:0] W_MAX   = WW'(DETECT_MIN);
  localparam logic [LW-1:0] L_MAX   = LW'(LEAK_MAX);
  localparam logic [CW-1:0] CD_INIT = CW'(COOLDOWN_FRAMES);
  localparam logic [2:0]    AMMO    = 3'(SHOTS_PER_ROUND);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_BLACK, S_WHITE, S_EVAL, S_COOL} state_e;

  state_e        state_q, state_d;
  logic [2:0]    shots_q, shots_d;
  logic [LW-1:0] leak_q, leak_d;
  logic [WW-1:0] white_q, white_d;
  logic [CW-1:0] cd_q, cd_d;
  logic          hit_d, miss_d, hit_q, miss_q, busy_q;
  logic [1:0]    flash_q;
  logic          trig_s1_q, trig_s2_q, trig_s3_q, det_s1_q, det_s2_q;
  logic          trig_rise, pix, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {trig_s1_q, trig_s2_q, trig_s3_q} <= 3'b000;
      {det_s1_q, det_s2_q}              <= 2'b00;
    end else begin
      {trig_s3_q, trig_s2_q, trig_s1_q} <= {trig_s2_q, trig_s1_q, trigger};
      {det_s2_q, det_s1_q}              <= {det_s1_q, detect};
    end
  end

  assign trig_rise = trig_s2_q & ~trig_s3_q;
  assign pix       = valid & det_s2_q;
  assign accept    = (state_q == S_IDLE) && trig_rise && (shots_q != 3'd0)
                     && duck_active && !round_start;

  always_comb begin
    state_d = state_q;
    shots_d = shots_q;
    leak_d  = leak_q;
    white_d = white_q;
    cd_d    = cd_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    if (round_start) begin
      state_d = S_IDLE;
      shots_d = AMMO;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          state_d = S_ARM;
          shots_d = shots_q - 3'd1;
          leak_d  = '0;
        end
        S_ARM: if (frame_start) state_d = S_BLACK;
        S_BLACK: begin
          if (pix && leak_q != L_MAX) leak_d = leak_q + LW'(1);
          if (frame_start) begin
            state_d = S_WHITE;
            white_d = '0;
          end
        end
        S_WHITE: begin
          if (pix && white_q != W_MAX) white_d = white_q + WW'(1);
          // Judge here so the registered pulse lands in the single EVAL cycle.
          if (frame_start) begin
            state_d = S_EVAL;
            if (white_q >= W_MAX && leak_q < L_MAX) hit_d = 1'b1;
            else                                    miss_d = 1'b1;
          end
        end
        S_EVAL: begin
          if (CD_INIT == '0) state_d = S_IDLE;
          else begin
            state_d = S_COOL;
            cd_d    = CD_INIT;
          end
        end
        S_COOL: if (frame_start) begin
          cd_d = cd_q - CW'(1);
          if (cd_q <= CW'(1)) begin
            cd_d    = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shots_q <= AMMO;
      leak_q  <= '0;
      white_q <= '0;
      cd_q    <= '0;
      flash_q <= 2'b00;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shots_q <= shots_d;
      leak_q  <= leak_d;
      white_q <= white_d;
      cd_q    <= cd_d;
      flash_q <= (state_d == S_BLACK) ? 2'b01 : (state_d == S_WHITE) ? 2'b10 : 2'b00;
      busy_q  <= (state_d != S_IDLE);
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign flash_mode = flash_q;
  assign busy       = busy_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign shots_left = shots_q;

`ifdef ZAPPER_STATS_EN
  logic [7:0] shots_tot_q, hits_tot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shots_tot_q <= 8'd0;
      hits_tot_q  <= 8'd0;
    end else begin
      if (accept && shots_tot_q != 8'hFF) shots_tot_q <= shots_tot_q + 8'd1;
      if (hit_d && hits_tot_q != 8'hFF)   hits_tot_q  <= hits_tot_q + 8'd1;
    end
  end

  assign shots_total = shots_tot_q;
  assign hits_total  = hits_tot_q;
`endif

endmodule

// File: tb/tb_zapper_flash_ctrl.sv
// Randomized frame-level stimulus for zapper_flash_ctrl; result pulses checked by a scoreboard.
module tb_zapper_flash_ctrl;
  localparam int SHOTS = 3, DMIN = 16, LMAX = 8, CDF = 8;
  localparam int FL = 64, NF = 260;

  logic clk = 1'b0, rst_n = 1'b0;
  logic frame_start = 1'b0, valid = 1'b0, trigger = 1'b0, detect = 1'b0;
  logic duck_active = 1'b0, round_start = 1'b0;
  logic [1:0] flash_mode;
  logic       hit_pulse, miss_pulse, busy;
  logic [2:0] shots_left;
`ifdef ZAPPER_STATS_EN
  logic [7:0] shots_total, hits_total;
`endif

  zapper_flash_ctrl #(
    .SHOTS_PER_ROUND(SHOTS), .DETECT_MIN(DMIN), .LEAK_MAX(LMAX), .COOLDOWN_FRAMES(CDF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .valid(valid),
    .trigger(trigger), .detect(detect), .duck_active(duck_active),
    .round_start(round_start), .flash_mode(flash_mode), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .shots_left(shots_left),
`ifdef ZAPPER_STATS_EN
    .shots_total(shots_total), .hits_total(hits_total),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int frame; bit hit;} exp_t;
  typedef enum {M_IDLE, M_ARM, M_BLK, M_WHT, M_CD} mst_e;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   frame_no = -1, cyc = 0;
  mst_e ms;
  int   ammo, mcd, mleak, mwhite, m_shots, m_hits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (frame %0d cyc %0d)", name, act, exp, frame_no, cyc);
    end
  endtask

  task automatic m_accept(input bit d);
    if (ammo > 0 && d) begin
      ammo--;
      ms = M_ARM;
      if (m_shots < 255) m_shots++;
    end
  endtask

  // Scoreboard monitor: every result pulse must match the oldest expected shot outcome.
  always @(negedge clk) begin
    exp_t e;
    if (hit_pulse === 1'b1 || miss_pulse === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: hit=%0b miss=%0b at frame %0d cyc %0d, expected none",
                 hit_pulse, miss_pulse, frame_no, cyc);
      end else begin
        e = sb.pop_front();
        if (hit_pulse !== e.hit || miss_pulse !== !e.hit || frame_no != e.frame || cyc != 1) begin
          errors++;
          $display("FAIL result: hit=%0b miss=%0b frame %0d cyc %0d, expected hit=%0b frame %0d cyc 1",
                   hit_pulse, miss_pulse, frame_no, cyc, e.hit, e.frame);
        end
      end
    end
  end

  initial begin
    int   n, held_left;
    bit   duck, trg20, hold, tr62, pend62, rs0, rs40, rst30, hv;
    mst_e pre;
    ms = M_IDLE; ammo = SHOTS; mcd = 0; mleak = 0; mwhite = 0; m_shots = 0; m_hits = 0;
    pend62 = 1'b0; held_left = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_flash", flash_mode, 0);
    chk("reset_busy", busy, 0);
    chk("reset_shots", shots_left, SHOTS);
    chk("reset_hit", hit_pulse, 0);
    chk("reset_miss", miss_pulse, 0);
    rst_n = 1'b1;

    for (int f = 0; f < NF; f++) begin
      rs0 = ($urandom_range(0, 99) < ((ms == M_WHT) ? 20 : 1));
      if (ms == M_ARM)
        n = ($urandom_range(0, 9) < 7) ? $urandom_range(0, LMAX - 1) : $urandom_range(LMAX, 48);
      else if (ms == M_BLK)
        n = ($urandom_range(0, 9) < 6) ? $urandom_range(DMIN, 48) : $urandom_range(0, DMIN - 1);
      else
        n = $urandom_range(0, 48);
      duck  = ($urandom_range(0, 99) < 85);
      trg20 = (held_left == 0) && ($urandom_range(0, 99) < 40);
      hold  = trg20 && ($urandom_range(0, 9) == 0);
      tr62  = (held_left == 0) && !trg20 && ($urandom_range(0, 99) < 12);
      rs40  = ($urandom_range(0, 99) < 2);
      rst30 = (held_left == 0) && !hold && ($urandom_range(0, 99) < ((ms == M_ARM) ? 15 : 1));

      for (int c = 0; c < FL; c++) begin
        @(posedge clk);
        #1;
        cyc = c;
        if (c == 0) frame_no = f;
        frame_start = (c == 0);
        valid       = (c >= 8 && c < 56);
        detect      = (c >= 6 && c < 6 + n);
        round_start = (c == 0 && rs0) || (c == 40 && rs40);
        if (c == 0) duck_active = duck;
        trigger = (held_left > 1) || (held_left == 1 && c < 50) ||
                  (trg20 && c >= 20 && (hold || c < 23)) || (tr62 && c >= 62) ||
                  (pend62 && c == 0);

        if (c == 0) begin
          if (rs0) begin
            ms = M_IDLE; ammo = SHOTS;
          end else begin
            pre = ms;
            case (ms)
              M_ARM: begin ms = M_BLK; mleak = n; end
              M_BLK: begin ms = M_WHT; mwhite = n; end
              M_WHT: begin
                hv = (mwhite >= DMIN) && (mleak < LMAX);
                sb.push_back('{f, hv});
                if (hv && m_hits < 255) m_hits++;
                if (CDF == 0) ms = M_IDLE;
                else begin ms = M_CD; mcd = CDF; end
              end
              M_CD: begin mcd--; if (mcd == 0) ms = M_IDLE; end
              default: ;
            endcase
            if (pre == M_IDLE && pend62) m_accept(duck);
          end
        end
        if (c == 22 && trg20 && ms == M_IDLE) m_accept(duck);
        if (c == 30 && rst30) begin
          rst_n = 1'b0;
          ms = M_IDLE; ammo = SHOTS; m_shots = 0; m_hits = 0;
          #1;
          chk("async_rst_flash", flash_mode, 0);
          chk("async_rst_busy", busy, 0);
          chk("async_rst_shots", shots_left, SHOTS);
          chk("async_rst_pulse", {hit_pulse, miss_pulse}, 0);
        end
        if (c == 31 && rst30) rst_n = 1'b1;
        if (c == 32) begin
          #2;
          chk("flash_mode", flash_mode, (ms == M_BLK) ? 1 : (ms == M_WHT) ? 2 : 0);
          chk("busy", busy, (ms != M_IDLE));
          chk("shots_left", shots_left, ammo);
          chk("missing_result", sb.size(), 0);
`ifdef ZAPPER_STATS_EN
          chk("shots_total", shots_total, m_shots);
          chk("hits_total", hits_total, m_hits);
`endif
        end
        if (c == 40 && rs40) begin
          ms = M_IDLE; ammo = SHOTS;
        end
      end
      pend62 = tr62;
      if (hold) held_left = $urandom_range(1, 5);
      else if (held_left > 0) held_left--;
    end

    @(posedge clk);
    #1;
    frame_start = 1'b0; valid = 1'b0; trigger = 1'b0; detect = 1'b0; round_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
